pipeline_stall_controller: RTL

- Central interlock and sequencing controller for the 5-stage MIPS pipeline.
- Raises PC/IF-ID stall and ID-EX bubble for load-use hazards. Register-to-register hazards are not handled here; the forwarding units cover them.
- Schedules the multi-cycle multiply/divide unit (MDU) and holds HI/LO consumers until the result is ready.
- Converts a taken branch resolved in EX into IF-ID/ID-EX flushes.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/pipeline_stall_controller_if.sv | 32 +++
 rtl/mdu_sequencer.sv | 66 ++++++
 rtl/pipeline_stall_controller.sv | 76 +++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the MDU sequencer state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [2:0] OP_STORE = 3'b101;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// ID/EX hazard inputs and stall/flush/MDU control outputs.
interface pipeline_stall_controller_if;
  logic [5:0] id_opcode;
  logic [5:0] id_func;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_mem_read;
  logic [4:0] ex_write_reg;
  logic       ex_branch_taken;
  logic       pc_stall;
  logic       ifid_stall;
  logic       idex_bubble;
  logic       ifid_flush;
  logic       mdu_start;
  logic       mdu_is_div;
  logic       mdu_busy;
  logic       mdu_done;

  modport master (
    output id_opcode, id_func, id_rs, id_rt,
    output ex_mem_read, ex_write_reg, ex_branch_taken,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush,
    input  mdu_start, mdu_is_div, mdu_busy, mdu_done
  );

  modport slave (
    input  id_opcode, id_func, id_rs, id_rt,
    input  ex_mem_read, ex_write_reg, ex_branch_taken,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush,
    output mdu_start, mdu_is_div, mdu_busy, mdu_done
  );
endinterface

// File: rtl/mdu_sequencer.sv
// MDU launch/countdown FSM: busy for N cycles after start, then a done pulse.
module mdu_sequencer
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic is_div,
  output logic start,
  output logic start_is_div,
  output logic busy,
  output logic done
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    start        = 1'b0;
    start_is_div = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          start        = 1'b1;
          start_is_div = is_div;
          state_d      = RUN;
          cnt_d        = is_div ? CNT_W'(DIV_CYCLES - 1)
                                : CNT_W'(MULT_CYCLES - 1);
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Load-use interlock, HI/LO hold, MDU issue and branch flush for the pipeline.
module pipeline_stall_controller
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input logic clk,
  input logic rst,
  pipeline_stall_controller_if.slave bus
);

  logic is_rtype, is_shift, is_jump;
  logic uses_rs, uses_rt;
  logic is_mdu_op, is_div, is_hilo_use;
  logic load_use, mdu_hold, stall, issue;
  logic busy;

  assign is_rtype = (bus.id_opcode == OP_RTYPE);
  assign is_jump  = (bus.id_opcode == OP_J) ||
                    (bus.id_opcode == OP_JAL);
  assign is_shift = is_rtype &&
                    ((bus.id_func == FN_SLL) ||
                     (bus.id_func == FN_SRL) ||
                     (bus.id_func == FN_SRA));

  assign uses_rs = !is_jump && !is_shift;
  assign uses_rt = is_rtype ||
                   (bus.id_opcode == OP_BEQ) ||
                   (bus.id_opcode == OP_BNE) ||
                   (bus.id_opcode[5:3] == OP_STORE);

  assign is_mdu_op = is_rtype &&
                     (bus.id_func >= FN_MULT) &&
                     (bus.id_func <= FN_DIVU);
  assign is_div      = bus.id_func[1];
  assign is_hilo_use = is_rtype &&
                       (bus.id_func >= FN_MFHI) &&
                       (bus.id_func <= FN_MTLO);

  assign load_use =
    bus.ex_mem_read && (bus.ex_write_reg != 5'd0) &&
    ((uses_rs && bus.id_rs == bus.ex_write_reg) ||
     (uses_rt && bus.id_rt == bus.ex_write_reg));

  assign mdu_hold = busy && (is_mdu_op || is_hilo_use);

  // Wrong-path ID instruction: a taken branch beats every stall.
  assign stall = !rst && (load_use || mdu_hold) &&
                 !bus.ex_branch_taken;
  assign issue = !rst && is_mdu_op && !load_use &&
                 !bus.ex_branch_taken;

  assign bus.pc_stall    = stall;
  assign bus.ifid_stall  = stall;
  assign bus.idex_bubble = stall || (!rst && bus.ex_branch_taken);
  assign bus.ifid_flush  = !rst && bus.ex_branch_taken;
  assign bus.mdu_busy    = busy;

  mdu_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .is_div       (is_div),
    .start        (bus.mdu_start),
    .start_is_div (bus.mdu_is_div),
    .busy         (busy),
    .done         (bus.mdu_done)
  );

endmodule
